// File: rtl/ysyx_22040175_mem_arb_pkg.sv
// Shared types for the IFU/LSU data-memory arbiter: FSM states, owner encoding
// and the width of the BUSY timeout counter.
package ysyx_22040175_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam int TO_W = 8;

endpackage

// File: rtl/ysyx_22040175_mem_arb_if.sv
// Bundle of requester-side (IFU, LSU) and memory-side signals of the arbiter.
// The arbiter uses the slave modport; the surrounding core/memory use master.
interface ysyx_22040175_mem_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            ifu_req;
    logic [AW-1:0]   ifu_addr;
    logic            ifu_gnt;
    logic            ifu_rvalid;
    logic [DW-1:0]   ifu_rdata;

    logic            lsu_req;
    logic            lsu_we;
    logic [AW-1:0]   lsu_addr;
    logic [DW-1:0]   lsu_wdata;
    logic [DW/8-1:0] lsu_wmask;
    logic            lsu_gnt;
    logic            lsu_rvalid;
    logic [DW-1:0]   lsu_rdata;

    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_wmask;
    logic            mem_ready;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  ifu_req, ifu_addr,
        output ifu_gnt, ifu_rvalid, ifu_rdata,
        input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
        output lsu_gnt, lsu_rvalid, lsu_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ready, mem_rdata
    );

    modport master (
        output ifu_req, ifu_addr,
        input  ifu_gnt, ifu_rvalid, ifu_rdata,
        output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
        input  lsu_gnt, lsu_rvalid, lsu_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/ysyx_22040175_mem_arb_rr_pick.sv
// Two-way round-robin picker: req[0]=IFU, req[1]=LSU; on a tie the requester
// that did not own the previous access wins. grant is one-hot or zero.
module ysyx_22040175_rr_pick
    import ysyx_22040175_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last_owner,
    output logic [1:0] grant
);

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_owner == OWN_LSU) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_22040175_mem_arb.sv
// IFU/LSU arbiter in front of the single-port data memory (IDLE/BUSY/RESP FSM).
// Optional build macro YSYX_22040175_MEM_ARB_PERF_EN adds saturating perf counters.
module ysyx_22040175_mem_arb
    import ysyx_22040175_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    ysyx_22040175_mem_arb_if.slave   bus,
    output logic                     err
`ifdef YSYX_22040175_MEM_ARB_PERF_EN
    ,
    output logic [31:0]              perf_ifu_cnt,
    output logic [31:0]              perf_lsu_cnt,
    output logic [31:0]              perf_stall_cnt
`endif
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e          state_q, state_d;
    owner_e          owner_q, last_owner_q;
    logic [TO_W-1:0] cnt_q;
    logic            timed_out_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] wmask_q;
    logic [DW-1:0]   ifu_rdata_q, lsu_rdata_q;

    logic [1:0]      grant;
    logic            idle_ok, ifu_gnt, lsu_gnt, abort;

    ysyx_22040175_rr_pick u_pick (
        .req        ({bus.lsu_req, bus.ifu_req}),
        .last_owner (last_owner_q),
        .grant      (grant)
    );

    // Grants exist only in IDLE and are suppressed while reset is being applied.
    assign idle_ok = (state_q == IDLE) && !rst;
    assign ifu_gnt = idle_ok && grant[0];
    assign lsu_gnt = idle_ok && grant[1];
    assign abort   = (state_q == BUSY) && !bus.mem_ready && (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ifu_gnt || lsu_gnt) state_d = BUSY;
            BUSY:    if (bus.mem_ready || abort) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= OWN_IFU;
            last_owner_q <= OWN_LSU;
            cnt_q        <= '0;
            timed_out_q  <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            ifu_rdata_q  <= '0;
            lsu_rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q       <= '0;
                    timed_out_q <= 1'b0;
                    if (ifu_gnt) begin
                        owner_q <= OWN_IFU;
                        we_q    <= 1'b0;
                        addr_q  <= bus.ifu_addr;
                        wdata_q <= '0;
                        wmask_q <= '0;
                    end else if (lsu_gnt) begin
                        owner_q <= OWN_LSU;
                        we_q    <= bus.lsu_we;
                        addr_q  <= bus.lsu_addr;
                        wdata_q <= bus.lsu_wdata;
                        wmask_q <= bus.lsu_wmask;
                    end
                end
                BUSY: begin
                    if (bus.mem_ready) begin
                        if (owner_q == OWN_IFU) ifu_rdata_q <= bus.mem_rdata;
                        else                    lsu_rdata_q <= we_q ? '0 : bus.mem_rdata;
                    end else if (abort) begin
                        timed_out_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP:    last_owner_q <= owner_q;
                default: ;
            endcase
        end
    end

    assign bus.ifu_gnt    = ifu_gnt;
    assign bus.lsu_gnt    = lsu_gnt;
    assign bus.mem_req    = (state_q == BUSY);
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_wmask  = wmask_q;
    assign bus.ifu_rdata  = ifu_rdata_q;
    assign bus.lsu_rdata  = lsu_rdata_q;
    assign bus.ifu_rvalid = (state_q == RESP) && !timed_out_q && (owner_q == OWN_IFU);
    assign bus.lsu_rvalid = (state_q == RESP) && !timed_out_q && (owner_q == OWN_LSU);
    assign err            = (state_q == RESP) && timed_out_q;

`ifdef YSYX_22040175_MEM_ARB_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ifu_cnt   <= '0;
            perf_lsu_cnt   <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (bus.ifu_rvalid) perf_ifu_cnt <= sat_inc(perf_ifu_cnt);
            if (bus.lsu_rvalid) perf_lsu_cnt <= sat_inc(perf_lsu_cnt);
            if ((bus.ifu_req && !ifu_gnt) || (bus.lsu_req && !lsu_gnt))
                perf_stall_cnt <= sat_inc(perf_stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22040175_mem_arb.sv
// Scoreboard bench for ysyx_22040175_mem_arb: stimulus pushes expected responses
// and memory requests; monitor and memory-model processes pop and compare.
module tb_ysyx_22040175_mem_arb;
    import ysyx_22040175_arb_pkg::*;

    localparam int TIMEOUT = 255;

    typedef struct {
        logic [2:0]  flags;   // {lsu_rvalid, ifu_rvalid, err}
        logic [31:0] rdata;
        int          lat;     // cycles from grant to response, -1 = don't care
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mreq_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err;
`ifdef YSYX_22040175_MEM_ARB_PERF_EN
    logic [31:0] perf_ifu_cnt, perf_lsu_cnt, perf_stall_cnt;
`endif

    ysyx_22040175_mem_arb_if #(.AW(32), .DW(32)) bus ();

    ysyx_22040175_mem_arb #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .err            (err)
`ifdef YSYX_22040175_MEM_ARB_PERF_EN
        ,
        .perf_ifu_cnt   (perf_ifu_cnt),
        .perf_lsu_cnt   (perf_lsu_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    gnt_cyc = 0;
    bit    mon_en = 1'b0;
    bit    mem_hang = 1'b0;
    int    mem_lat = 0;
    exp_t  exp_q[$];
    mreq_t mem_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_image(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h5A5A_A5A5);
    endfunction

    function automatic logic [31:0] ifu_a(input int i);
        return 32'h8000_0100 + 32'(i * 4);
    endfunction

    function automatic logic [31:0] lsu_a(input int i);
        return 32'h8000_0200 + 32'(i * 4);
    endfunction

    task automatic push_exp(input logic [2:0] flags, input logic [31:0] d, input int lat);
        exp_t e;
        e.flags = flags; e.rdata = d; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic push_mem(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] wm);
        mreq_t m;
        m.we = we; m.addr = a; m.wdata = wd; m.wmask = wm;
        mem_q.push_back(m);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Response monitor: every rvalid/err pulse must match the head of the scoreboard.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (bus.ifu_gnt || bus.lsu_gnt) gnt_cyc = cyc;
            if (bus.ifu_rvalid || bus.lsu_rvalid || err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", {bus.lsu_rvalid, bus.ifu_rvalid, err}, 3'b000);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_flags", {bus.lsu_rvalid, bus.ifu_rvalid, err}, e.flags);
                    if (e.flags == 3'b010) check("ifu_rdata", bus.ifu_rdata, e.rdata);
                    if (e.flags == 3'b100) check("lsu_rdata", bus.lsu_rdata, e.rdata);
                    if (e.flags == 3'b001) check("err_mem_req", bus.mem_req, 1'b0);
                    if (e.lat >= 0) check("resp_latency", 32'(cyc - gnt_cyc), 32'(e.lat));
                end
            end
        end
    end

    // Memory model: checks the presented fields on every BUSY cycle, answers after mem_lat.
    initial begin
        int    busy_idx = 0;
        mreq_t cur;
        cur.we = 1'b0; cur.addr = '0; cur.wdata = '0; cur.wmask = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req) begin
                if (busy_idx == 0) begin
                    if (mem_q.size() == 0) check("unexpected_mem_req", bus.mem_req, 1'b0);
                    else cur = mem_q.pop_front();
                end
                check("mem_fields", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask},
                      {cur.we, cur.addr, cur.wdata, cur.wmask});
                if (!mem_hang && busy_idx == mem_lat) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = mem_image(bus.mem_addr);
                end else begin
                    bus.mem_ready = 1'b0;
                    bus.mem_rdata = 32'hBAD0_BAD0;
                end
                busy_idx++;
            end else begin
                busy_idx = 0;
                bus.mem_ready = 1'b0;
            end
        end
    end

    task automatic wait_gnt(input bit lsu);
        int  g = 0;
        bit  got = 1'b0;
        while (!got && g < 400) begin
            @(negedge clk);
            got = lsu ? bus.lsu_gnt : bus.ifu_gnt;
            g++;
        end
        if (!got) check(lsu ? "lsu_gnt_wait" : "ifu_gnt_wait", 1'b0, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic wait_quiet();
        int g = 0;
        while (exp_q.size() != 0 && g < 600) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) check("resp_wait", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic issue_ifu(input logic [31:0] a, input int lat, input bit want_resp,
                             input logic [2:0] flags, input logic [31:0] d, input int exp_lat);
        mem_lat = lat;
        push_mem(1'b0, a, 32'd0, 4'd0);
        if (want_resp) push_exp(flags, d, exp_lat);
        @(posedge clk); #1;
        bus.ifu_req = 1'b1;
        bus.ifu_addr = a;
        wait_gnt(1'b0);
        bus.ifu_req = 1'b0;
    endtask

    task automatic issue_lsu(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] wm, input int lat, input logic [31:0] d,
                             input int exp_lat);
        mem_lat = lat;
        push_mem(we, a, wd, wm);
        push_exp(3'b100, d, exp_lat);
        @(posedge clk); #1;
        bus.lsu_req = 1'b1;
        bus.lsu_we = we;
        bus.lsu_addr = a;
        bus.lsu_wdata = wd;
        bus.lsu_wmask = wm;
        wait_gnt(1'b1);
        bus.lsu_req = 1'b0;
    endtask

    // Both requesters keep requesting for n loads each; grants must alternate.
    task automatic run_both(input int n, input bit first_lsu);
        int ni = 0;
        int nl = 0;
        int guard = 0;
        bit gi, gl;
        mem_lat = 0;
        for (int k = 0; k < 2 * n; k++) begin
            bit is_lsu;
            is_lsu = ((k % 2) == 1) ^ first_lsu;
            if (is_lsu) begin
                push_mem(1'b0, lsu_a(k / 2), 32'd0, 4'd0);
                push_exp(3'b100, mem_image(lsu_a(k / 2)), 2);
            end else begin
                push_mem(1'b0, ifu_a(k / 2), 32'd0, 4'd0);
                push_exp(3'b010, mem_image(ifu_a(k / 2)), 2);
            end
        end
        @(posedge clk); #1;
        bus.ifu_req = 1'b1; bus.ifu_addr = ifu_a(0);
        bus.lsu_req = 1'b1; bus.lsu_we = 1'b0; bus.lsu_addr = lsu_a(0);
        bus.lsu_wdata = '0; bus.lsu_wmask = '0;
        while ((ni < n || nl < n) && guard < 100 * n) begin
            @(negedge clk);
            gi = bus.ifu_gnt;
            gl = bus.lsu_gnt;
            @(posedge clk); #1;
            if (gi) begin
                ni++;
                if (ni < n) bus.ifu_addr = ifu_a(ni);
                else        bus.ifu_req = 1'b0;
            end
            if (gl) begin
                nl++;
                if (nl < n) bus.lsu_addr = lsu_a(nl);
                else        bus.lsu_req = 1'b0;
            end
            guard++;
        end
        if (ni < n || nl < n) check("both_gnt_wait", 32'(ni + nl), 32'(2 * n));
        bus.ifu_req = 1'b0;
        bus.lsu_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ifu_req = 1'b0; bus.ifu_addr = '0;
        bus.lsu_req = 1'b0; bus.lsu_we = 1'b0; bus.lsu_addr = '0;
        bus.lsu_wdata = '0; bus.lsu_wmask = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_rvalid_err", {bus.ifu_rvalid, bus.lsu_rvalid, err}, 3'b000);
        check("rst_gnt", {bus.ifu_gnt, bus.lsu_gnt}, 2'b00);
        check("rst_mem_fields", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask}, '0);
        check("rst_rdata", {bus.ifu_rdata, bus.lsu_rdata}, '0);
`ifdef YSYX_22040175_MEM_ARB_PERF_EN
        check("rst_perf", {perf_ifu_cnt, perf_lsu_cnt, perf_stall_cnt}, '0);
`endif
        mon_en = 1'b1;

        // Tie after reset: IFU first, then strict alternation over 8 accesses.
        run_both(4, 1'b0);
        wait_quiet();
`ifdef YSYX_22040175_MEM_ARB_PERF_EN
        check("perf_ifu_cnt", perf_ifu_cnt, 32'd4);
        check("perf_lsu_cnt", perf_lsu_cnt, 32'd4);
        check("perf_stall_nz", perf_stall_cnt != 0, 1'b1);
`endif

        // IFU alone, memory answers in the second BUSY cycle -> rvalid 3 cycles after grant.
        issue_ifu(32'h8000_0000, 1, 1'b1, 3'b010, 32'h0000_0413, 3);
        wait_quiet();

        // IFU owned last, so a tie now goes to LSU first.
        run_both(1, 1'b1);
        wait_quiet();

        // Store: fields stable through four BUSY cycles, lsu_rdata reads back as zero.
        issue_lsu(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 3, 32'd0, 5);
        wait_quiet();

        // Memory never answers: err after TIMEOUT BUSY cycles, then normal service resumes.
        mem_hang = 1'b1;
        issue_ifu(32'h8000_0020, 0, 1'b1, 3'b001, 32'd0, TIMEOUT + 1);
        wait_quiet();
        mem_hang = 1'b0;
        issue_lsu(1'b0, 32'h8000_0030, 32'd0, 4'd0, 0, mem_image(32'h8000_0030), 2);
        wait_quiet();

        // Leave IFU as last owner, then abandon an IFU access with reset mid-BUSY.
        issue_ifu(32'h8000_0034, 0, 1'b1, 3'b010, mem_image(32'h8000_0034), 2);
        wait_quiet();
        mem_hang = 1'b1;
        issue_ifu(32'h8000_0040, 0, 1'b0, 3'b000, 32'd0, -1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        mem_hang = 1'b0;
        @(negedge clk);
        check("rst_mid_mem_req", bus.mem_req, 1'b0);
        repeat (3) @(posedge clk);
        run_both(1, 1'b0);
        wait_quiet();

        check("mem_q_left", 32'(mem_q.size()), 32'd0);
        check("exp_q_left", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
